uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type; UART_RX_PARITY_EN adds the PARITY state
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT    = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
`endif

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer with a parameterised reset value
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with valid/ready output; UART_RX_PARITY_EN adds an even-parity bit and parity_err_o
import uart_pkg::*;

module uart_rx #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_err_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam int             BCW       = $clog2(DATA_BITS + 1);
    localparam logic [15:0]    HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]    BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);

    logic                 rxs;
    logic                 rxs_q;
    rx_state_t            state;
    logic [15:0]          cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 byte_done;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (uart_rx_i),
        .q     (rxs)
    );

    // A frame is delivered only on a high mid-stop sample (and matching parity when enabled).
    always_comb begin
        byte_done = 1'b0;
        if (state == STOP && cnt == BIT_LAST && rxs) begin
`ifdef UART_RX_PARITY_EN
            byte_done = ((^shift) == par_bit);
`else
            byte_done = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            rxs_q         <= 1'b1;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            parity_err_o  <= 1'b0;
`endif
        end else begin
            rxs_q         <= rxs;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rxs_q && !rxs) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if ((^shift) != par_bit) parity_err_o <= 1'b1;
`endif
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A completed byte may replace the held one only when it is being consumed this cycle.
            if (byte_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift;
                    valid_o <= 1'b1;
                end else begin
                    overrun_err_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       line  = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .uart_rx_i     (line),
        .data_o        (data),
        .valid_o       (valid),
        .ready_i       (ready),
        .frame_err_o   (ferr),
        .overrun_err_o (ovr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o  (perr)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    int         exp_perr = 0;
    int         acc_cnt  = 0;
    int         valid_cycles = 0;
    logic [7:0] last_acc = 8'h00;
    bit         mon_en = 1'b0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: the outcome of each frame is decided at the start of its stop bit from line-level facts.
    task automatic send_frame(input logic [7:0] d, input int stop_low, input bit model_en, input bit par_flip);
        line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        line = (^d) ^ par_flip;
        tick(CPB);
`endif
        if (model_en) begin
            if (stop_low > 0)                      exp_ferr++;
            else if (par_flip)                     exp_perr++;
            else if (!ready && exp_q.size() > 0)   exp_ovr++;
            else                                   exp_q.push_back(d);
        end
        if (stop_low > 0) begin
            line = 1'b0;
            tick(stop_low);
        end
        line = 1'b1;
        tick(CPB);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    check_eq("valid_o with no byte expected", 32'(valid), 32'd0);
                end else begin
                    check_eq("data_o held byte", 32'(data), 32'(exp_q[0]));
                    if (ready) begin
                        last_acc = data;
                        acc_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (ferr) begin
                check_eq("frame_err_o pulse expected", 32'(exp_ferr > 0), 32'd1);
                if (exp_ferr > 0) exp_ferr--;
            end
            if (ovr) begin
                check_eq("overrun_err_o pulse expected", 32'(exp_ovr > 0), 32'd1);
                if (exp_ovr > 0) exp_ovr--;
            end
`ifdef UART_RX_PARITY_EN
            if (perr) begin
                check_eq("parity_err_o pulse expected", 32'(exp_perr > 0), 32'd1);
                if (exp_perr > 0) exp_perr--;
            end
`endif
        end
    end

    initial begin
        int   gap;
        int   sl;
        bit   pf;
        logic [7:0] d;

        rst = 1'b1;
        tick(3);
        check_eq("reset valid_o", 32'(valid), 32'd0);
        check_eq("reset data_o", 32'(data), 32'd0);
        check_eq("reset frame_err_o", 32'(ferr), 32'd0);
        check_eq("reset overrun_err_o", 32'(ovr), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(5);

        valid_cycles = 0;
        send_frame(8'hA5, 0, 1'b1, 1'b0);
        tick(5);
        check_eq("A5 valid cycles", 32'(valid_cycles), 32'd1);
        check_eq("A5 data", 32'(last_acc), 32'hA5);

        line = 1'b0;
        tick(4);
        line = 1'b1;
        tick(30);
        check_eq("glitch no valid", 32'(valid_cycles), 32'd1);
        send_frame(8'h3C, 0, 1'b1, 1'b0);
        tick(5);
        check_eq("3C after glitch", 32'(last_acc), 32'h3C);

        send_frame(8'h55, 40, 1'b1, 1'b0);
        tick(5);
        check_eq("break frame_err seen", 32'(exp_ferr), 32'd0);
        check_eq("break byte dropped", 32'(acc_cnt), 32'd2);
        send_frame(8'h81, 0, 1'b1, 1'b0);
        tick(5);
        check_eq("81 after break", 32'(last_acc), 32'h81);

        ready = 1'b0;
        send_frame(8'h11, 0, 1'b1, 1'b0);
        send_frame(8'h22, 0, 1'b1, 1'b0);
        tick(5);
        check_eq("overrun keeps old data", 32'(data), 32'h11);
        check_eq("overrun keeps valid", 32'(valid), 32'd1);
        check_eq("overrun pulse seen", 32'(exp_ovr), 32'd0);
        ready = 1'b1;
        tick(3);
        check_eq("11 consumed", 32'(last_acc), 32'h11);
        check_eq("valid falls after consume", 32'(valid), 32'd0);

        ready = 1'b0;
        send_frame(8'h11, 0, 1'b1, 1'b0);
        tick(5);
        fork
            send_frame(8'hF8, 0, 1'b0, 1'b0);
            begin
                tick(CPB + 3 * CPB + CPB / 2);
                rst = 1'b1;
                tick(1);
                exp_q.delete();
                check_eq("midframe reset valid_o", 32'(valid), 32'd0);
                check_eq("midframe reset data_o", 32'(data), 32'd0);
                check_eq("midframe reset frame_err_o", 32'(ferr), 32'd0);
                check_eq("midframe reset overrun_err_o", 32'(ovr), 32'd0);
                rst = 1'b0;
            end
        join
        ready = 1'b1;
        tick(10);
        send_frame(8'hF0, 0, 1'b1, 1'b0);
        tick(5);
        check_eq("F0 after reset", 32'(last_acc), 32'hF0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 0, 1'b1, 1'b0);
        tick(5);
        check_eq("07 good parity", 32'(last_acc), 32'h07);
        send_frame(8'h07, 0, 1'b1, 1'b1);
        tick(5);
        check_eq("07 bad parity pulse seen", 32'(exp_perr), 32'd0);
`endif

        for (int n = 0; n < 24; n++) begin
            d     = 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            sl    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 40)) : 0;
            pf    = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf    = ($urandom_range(0, 5) == 0);
`endif
            send_frame(d, sl, 1'b1, pf);
            gap = int'($urandom_range(0, 20));
            if (gap > 0) tick(gap);
        end

        tick(20);
        ready = 1'b1;
        tick(5);
        check_eq("final queue drained", 32'(exp_q.size()), 32'd0);
        check_eq("final frame_err outstanding", 32'(exp_ferr), 32'd0);
        check_eq("final overrun outstanding", 32'(exp_ovr), 32'd0);
        check_eq("final parity outstanding", 32'(exp_perr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
